// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the receive endpoint, the master and the bench.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } spi_rx_state_e;

    typedef logic [SPI_DATA_W-1:0] spi_word_t;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// N-stage flop synchroniser for a single asynchronous bit.
//   clk   : system clock
//   rst   : asynchronous active-low reset; all stages load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronised output (STAGES clk edges of latency)
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain: d_i enters at bit 0 and leaves at the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx.sv
// SPI receive endpoint: oversamples sclk/cs/mosi in the clk domain and
// deserialises each cs-low frame into a DATA_W-bit word.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   sclk      : SPI clock (idle low, mosi sampled on rising edge)
//   cs        : chip select, active-low
//   mosi      : serial data
//   dout      : last complete word, held until the next complete frame
//   done      : 1-cycle pulse when dout updates
//   busy      : high while a frame is in progress
//   frame_err : 1-cycle pulse when cs rises before DATA_W bits arrived
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter bit          LSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic s_sclk, s_cs, s_mosi;
    logic sclk_prev_q;
    logic s_sclk_rise_c;

    spi_rx_state_e      state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q;

    // Pin synchronisers; reset values match the idle bus (sclk low, cs high).
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .d_i (sclk), .q_o (s_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .rst (rst), .d_i (cs),   .q_o (s_cs)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .d_i (mosi), .q_o (s_mosi)
    );

    assign s_sclk_rise_c = s_sclk & ~sclk_prev_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_prev_q <= s_sclk;
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    // Next-state logic. In SHIFT a sclk rise outranks a simultaneous cs rise,
    // so a last bit arriving together with cs deassertion still completes.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s_cs) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end

            SHIFT: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    dout_d  = shift_q;
                    done_d  = 1'b1;
                    state_d = WAIT_CS;
                end else if (s_sclk_rise_c) begin
                    if (LSB_FIRST) begin
                        shift_d = {s_mosi, shift_q[DATA_W-1:1]};
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], s_mosi};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (s_cs) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            WAIT_CS: begin
                if (s_cs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = err_q;

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: an LSB-first instance and an MSB-first
// instance share the same SPI pins.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int HALF = 5;   // clk cycles per sclk phase

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;

    spi_word_t dout, dout_m;
    logic done, busy, frame_err;
    logic done_m, busy_m, frame_err_m;

    int n_vec = 0;
    int n_err = 0;

    int done_cnt = 0, err_cnt = 0, both_cnt = 0, done_m_cnt = 0;
    spi_word_t got_q[$];
    logic busy_mid;

    spi_slave_rx #(.DATA_W(SPI_DATA_W), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
        .clk (clk), .rst (rst), .sclk (sclk), .cs (cs), .mosi (mosi),
        .dout (dout), .done (done), .busy (busy), .frame_err (frame_err)
    );

    spi_slave_rx #(.DATA_W(SPI_DATA_W), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_m (
        .clk (clk), .rst (rst), .sclk (sclk), .cs (cs), .mosi (mosi),
        .dout (dout_m), .done (done_m), .busy (busy_m), .frame_err (frame_err_m)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            got_q.push_back(dout);
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (done && frame_err) both_cnt = both_cnt + 1;
        if (done_m) done_m_cnt = done_m_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends bits[0] first; optionally deasserts cs afterwards.
    task automatic send_frame(input logic [15:0] bits, input int n, input bit end_cs);
        busy_mid = 1'b0;
        cs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            mosi = bits[i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            if (i == 1) busy_mid = busy;
        end
        wait_clk(HALF);
        if (end_cs) begin
            cs = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_vec++; if (dout !== 12'h000) begin n_err++; $display("FAIL reset_dout: got %h expected 000", dout); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic test_single();
        int d0, e0, m0;
        d0 = done_cnt; e0 = err_cnt; m0 = done_m_cnt;
        send_frame({4'h0, 12'hA5C}, 12, 1'b1);
        n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
        n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL single_frame_err: got %0d expected 0", err_cnt - e0); end
        n_vec++; if (dout !== 12'hA5C) begin n_err++; $display("FAIL single_dout: got %h expected a5c", dout); end
        n_vec++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL single_busy_mid: got %b expected 1", busy_mid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        n_vec++; if (done_m_cnt - m0 !== 1) begin n_err++; $display("FAIL single_msb_done_count: got %0d expected 1", done_m_cnt - m0); end
        n_vec++; if (dout_m !== 12'h3A5) begin n_err++; $display("FAIL single_msb_dout: got %h expected 3a5", dout_m); end
    endtask

    task automatic test_back_to_back();
        spi_word_t exp_w [20];
        int d0, e0;
        got_q.delete();
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            exp_w[i] = 12'($urandom());
            send_frame({4'h0, exp_w[i]}, 12, 1'b1);
        end
        n_vec++; if (done_cnt - d0 !== 20) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 20", done_cnt - d0); end
        n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL b2b_frame_err: got %0d expected 0", err_cnt - e0); end
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (i >= got_q.size()) begin
                n_err++; $display("FAIL b2b_word%0d: got none expected %h", i, exp_w[i]);
            end else if (got_q[i] !== exp_w[i]) begin
                n_err++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        int d0, e0;
        spi_word_t prev;
        prev = got_q.size() > 0 ? got_q[got_q.size()-1] : 12'h000;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(16'h0015, 5, 1'b1);
        n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL short_frame_err: got %0d expected 1", err_cnt - e0); end
        n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL short_done: got %0d expected 0", done_cnt - d0); end
        n_vec++; if (dout !== prev) begin n_err++; $display("FAIL short_dout_hold: got %h expected %h", dout, prev); end
    endtask

    task automatic test_zero_length();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        cs = 1'b0;
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(2 * HALF);
        n_vec++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL zero_len_frame_err: got %0d expected 1", err_cnt - e0); end
        n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL zero_len_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_extra_bits();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame({2'b00, 2'b11, 12'h3C3}, 14, 1'b1);
        n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL extra_done_count: got %0d expected 1", done_cnt - d0); end
        n_vec++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL extra_frame_err: got %0d expected 0", err_cnt - e0); end
        n_vec++; if (dout !== 12'h3C3) begin n_err++; $display("FAIL extra_dout: got %h expected 3c3", dout); end
        n_vec++; if (dout_m !== 12'hC3C) begin n_err++; $display("FAIL extra_msb_dout: got %h expected c3c", dout_m); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(16'h003F, 6, 1'b0);
        rst = 1'b0;
        wait_clk(2);
        n_vec++; if (dout !== 12'h000) begin n_err++; $display("FAIL midrst_dout: got %h expected 000", dout); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        cs = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(HALF);
        n_vec++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            n_err++; $display("FAIL midrst_pulses: got done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        send_frame(16'h0001, 12, 1'b1);
        n_vec++; if (dout !== 12'h001) begin n_err++; $display("FAIL midrst_new_dout: got %h expected 001", dout); end
        n_vec++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL midrst_new_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_bit_order();
        send_frame(16'h0801, 12, 1'b1);
        n_vec++; if (dout !== 12'h801) begin n_err++; $display("FAIL order_lsb_dout: got %h expected 801", dout); end
        n_vec++; if (dout_m !== 12'h801) begin n_err++; $display("FAIL order_msb_dout: got %h expected 801", dout_m); end
    endtask

    task automatic test_exclusive();
        n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL done_err_overlap: got %0d cycles expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_short_frame();
        test_zero_length();
        test_extra_bits();
        test_reset_mid_frame();
        test_bit_order();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_slave_rx
